axi_sram_slave: RTL and testbench
=================================

Name: axi_sram_slave

Overview:
- AXI3-style responder backed by an on-chip word-addressed SRAM array; the target end of the CPU's AXI master bridge.
- Serves as the memory model in CPU-level simulation and as a small on-chip RAM on FPGA.
- Independent read and write channel FSMs, one outstanding transaction per direction.
- Supports the INCR and WRAP bursts the bridge issues for cache-line refills and write-backs, plus narrow single transfers.

Parameters:
- MEM_WORDS, 4096: number of 32-bit words in the array; power of two.
- BASE_ADDR, 32'h1c00_0000: byte address of word 0.
- READ_LATENCY, 2: idle cycles between the AR handshake and the first R beat; 0 allowed.

Ports:
- clk in 1: clock.
- reset in 1: asynchronous, active-high reset.
- arid in 4, araddr in 32, arlen in 8, arsize in 3, arburst in 2, arvalid in 1: read address channel.
- arready out 1: read address ready.
- rid out 4, rdata out 32, rresp out 2, rlast out 1, rvalid out 1: read data channel.
- rready in 1: read data ready.
- awid in 4, awaddr in 32, awlen in 8, awsize in 3, awburst in 2, awvalid in 1: write address channel.
- awready out 1: write address ready.
- wdata in 32, wstrb in 4, wlast in 1, wvalid in 1: write data channel.
- wready out 1: write data ready.
- bid out 4, bresp out 2, bvalid out 1: write response channel.
- bready in 1: write response ready.

Behaviour:
- Reset, asynchronous: read FSM to R_IDLE, write FSM to W_IDLE.
  - arready=1, awready=1 (decoded from state).
  - rvalid=0, rlast=0, rdata=0, rid=0, rresp=0; wready=0; bvalid=0, bid=0, bresp=0.
  - The SRAM array is not reset; contents survive reset.
- Beat address sequence; bytes = 1<<size:
  - FIXED (00): address unchanged.
  - INCR (01): addr += bytes.
  - WRAP (10): addr = (addr & ~M) | ((addr+bytes) & M), with M = (len+1)*bytes-1. WRAP requires len in {1,3,7,15}; any other len is treated as INCR with SLVERR.
  - Burst 11 is treated as INCR with SLVERR.
- Word index = (addr-BASE_ADDR)>>2. A beat is in range iff BASE_ADDR <= addr < BASE_ADDR+4*MEM_WORDS, checked per beat.
- Narrow reads return the full addressed word. Narrow writes rely on wstrb only.
- Read FSM:
  - R_IDLE: arready=1. On arvalid, latch id/addr/len/size/burst and clear the beat counter. Go to R_WAIT, or to R_BURST if READ_LATENCY=0.
  - R_WAIT: count READ_LATENCY cycles, then go to R_BURST with rvalid=1.
  - R_BURST: rdata, rresp, rid and rlast are registered. They are loaded on entry and after each rvalid&&rready handshake, and held stable while rready=0.
  - rresp=00 in range. Out of range gives rresp=10 and rdata=0.
  - rlast=1 when beat counter == len.
  - The handshake on the last beat gives rvalid=0 and a return to R_IDLE. arready stays 0 outside R_IDLE.
  - First rvalid occurs exactly READ_LATENCY+1 cycles after the AR handshake edge.
- Write FSM:
  - W_IDLE: awready=1. On awvalid, latch the AW fields, clear the beat counter and the error flag, and go to W_DATA.
  - W_DATA: wready=1. W beats are never accepted before AW.
    - Each handshake writes the wstrb-enabled byte lanes of the array if in range; otherwise it sets the error flag.
    - The address advances per the burst rule.
    - If wlast disagrees with (counter==len), set the error flag. The write ends on the beat where counter==len regardless of wlast.
    - After the final beat: bvalid=1, bid=latched awid, bresp = error ? 10 : 00; go to W_RESP.
  - W_RESP: hold the B outputs until bready, then bvalid=0 and go to W_IDLE.
- Simultaneous read and write to the same word in one cycle: the read beat sees the old data (the read register loads before the array update).
- Read and write FSMs never stall each other.
- Reset mid-burst abandons the transaction; no partial B or R is emitted afterwards. Beats written before reset remain in the array.
- Beat counter is 8 bits; len=255 is supported with no wrap of the counter.

Test Plan:
- Single-word access:
  - Stimulus: AW id1 addr 0x1c000010 size2 len0 burst01, W 0xdeadbeef strb F wlast.
  - Required: B bid=1 bresp=00.
  - Then AR id0 same addr.
  - Required: first rvalid 3 cycles after the AR handshake, rdata=0xdeadbeef, rlast=1, rid=0.
- WRAP refill: after preloading words 0x20-0x2c with 0xA0..0xA3, AR addr 0x1c000028 len3 burst10 -> rdata sequence 0xA2,0xA3,0xA0,0xA1; rlast on the 4th beat only.
- INCR 4-beat write at 0x1c000100 with data 1,2,3,4, beat 2 strb 0011, word previously 0xffffffff -> word 0x104 reads 0xffff0002; the others read 1, 3, 4; bresp=00.
- rready backpressure: rready held low 3 cycles on beat 1 of a 4-beat read -> rvalid, rdata and rlast stable; all 4 beats delivered once, in order.
- Out-of-range accesses:
  - Read at 0x1c004000 with MEM_WORDS=4096 -> rdata=0, rresp=10 on every beat.
  - Write to the same address -> bresp=10, array unchanged.
  - Early wlast on beat 0 of len1 -> bresp=10.
- Mid-burst reset: reset asserted during beat 2 of a write and a read -> wready, rvalid and bvalid drop immediately while reset is high; arready=awready=1; beats 0-1 persist in the array.

Source files
------------

// File: rtl/axi_sram_slave.sv
// AXI3-style SRAM responder: word-addressed array behind independent read and
// write channel FSMs, one outstanding transaction per direction. Handles FIXED,
// INCR and WRAP bursts; illegal burst encodings run as INCR and answer SLVERR.
//
// Handshake semantics (all five channels): a transfer happens on a rising clk
// edge where both valid and ready are high. A source holding valid keeps its
// payload stable until that edge; ready never depends combinationally on valid.
module axi_sram_slave #(
  parameter int          MEM_WORDS    = 4096,
  parameter logic [31:0] BASE_ADDR    = 32'h1c00_0000,
  parameter int          READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int          IW        = $clog2(MEM_WORDS);
  localparam logic [32:0] LIMIT     = {1'b0, BASE_ADDR} + 33'(4 * MEM_WORDS);
  localparam logic [15:0] WAIT_LAST = 16'(READ_LATENCY);
  localparam logic [1:0]  OKAY      = 2'b00;
  localparam logic [1:0]  SLVERR    = 2'b10;

  // Effective address-advance rule after illegal encodings are folded to INCR.
  typedef enum logic [1:0] {M_FIXED, M_INCR, M_WRAP} mode_t;

  // FSM states are plain named registers so checkers can bind to rstate/wstate.
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;

  logic [31:0] mem [MEM_WORDS];

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

  function automatic mode_t burst_mode(input logic [1:0] burst, input logic [7:0] len);
    case (burst)
      2'b00:   return M_FIXED;
      2'b10:   return wrap_len_ok(len) ? M_WRAP : M_INCR;
      default: return M_INCR;
    endcase
  endfunction

  function automatic logic burst_err(input logic [1:0] burst, input logic [7:0] len);
    return (burst == 2'b11) || ((burst == 2'b10) && !wrap_len_ok(len));
  endfunction

  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [2:0] size,
                                            input logic [7:0] len, input mode_t mode);
    logic [31:0] bytes;
    logic [31:0] m;
    bytes = 32'd1 << size;
    m     = (({24'd0, len} + 32'd1) * bytes) - 32'd1;
    case (mode)
      M_FIXED: return a;
      M_WRAP:  return (a & ~m) | ((a + bytes) & m);
      default: return a + bytes;
    endcase
  endfunction

  function automatic logic in_range(input logic [31:0] a);
    return ({1'b0, a} >= {1'b0, BASE_ADDR}) && ({1'b0, a} < LIMIT);
  endfunction

  function automatic logic [IW-1:0] word_idx(input logic [31:0] a);
    return IW'((a - BASE_ADDR) >> 2);
  endfunction

  // ---------------- read channel ----------------
  rstate_t     rstate;
  logic [3:0]  r_id;
  logic [31:0] r_addr;
  logic [7:0]  r_len;
  logic [2:0]  r_size;
  mode_t       r_mode;
  logic        r_err;
  logic [7:0]  r_cnt;
  logic [15:0] r_wait;

  logic [31:0] r_next_addr;
  logic [31:0] r_load_addr;
  logic        r_load_inr;
  logic [31:0] r_load_data;
  logic [1:0]  r_load_resp;

  assign arready = (rstate == R_IDLE);

  // Beat fetch: first beat from the latched address, later beats from the advanced one.
  always_comb begin
    r_next_addr = next_addr(r_addr, r_size, r_len, r_mode);
    r_load_addr = (rstate == R_BURST) ? r_next_addr : r_addr;
    r_load_inr  = in_range(r_load_addr);
    r_load_data = r_load_inr ? mem[word_idx(r_load_addr)] : 32'd0;
    r_load_resp = (r_load_inr && !r_err) ? OKAY : SLVERR;
  end

  // Read FSM: latch AR, idle for the latency, then stream registered beats.
  // R_WAIT always lasts READ_LATENCY+1 cycles so the first beat reads the latched address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rstate <= R_IDLE;
      rvalid <= 1'b0;
      rlast  <= 1'b0;
      rdata  <= 32'd0;
      rid    <= 4'd0;
      rresp  <= OKAY;
      r_id   <= 4'd0;
      r_addr <= 32'd0;
      r_len  <= 8'd0;
      r_size <= 3'd0;
      r_mode <= M_INCR;
      r_err  <= 1'b0;
      r_cnt  <= 8'd0;
      r_wait <= 16'd0;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (arvalid) begin
            r_id   <= arid;
            r_addr <= araddr;
            r_len  <= arlen;
            r_size <= arsize;
            r_mode <= burst_mode(arburst, arlen);
            r_err  <= burst_err(arburst, arlen);
            r_cnt  <= 8'd0;
            r_wait <= 16'd0;
            rstate <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (r_wait == WAIT_LAST) begin
            rstate <= R_BURST;
            rvalid <= 1'b1;
            rid    <= r_id;
            rdata  <= r_load_data;
            rresp  <= r_load_resp;
            rlast  <= (r_len == 8'd0);
          end else begin
            r_wait <= r_wait + 16'd1;
          end
        end
        R_BURST: begin
          if (rready) begin
            if (rlast) begin
              rvalid <= 1'b0;
              rlast  <= 1'b0;
              rstate <= R_IDLE;
            end else begin
              r_addr <= r_next_addr;
              r_cnt  <= r_cnt + 8'd1;
              rdata  <= r_load_data;
              rresp  <= r_load_resp;
              rlast  <= ((r_cnt + 8'd1) == r_len);
            end
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  // ---------------- write channel ----------------
  wstate_t     wstate;
  logic [3:0]  w_id;
  logic [31:0] w_addr;
  logic [7:0]  w_len;
  logic [2:0]  w_size;
  mode_t       w_mode;
  logic        w_err;
  logic [7:0]  w_cnt;

  logic        w_hs;
  logic        w_inr;
  logic        w_final;
  logic        w_beat_err;
  logic [IW-1:0] w_idx;

  assign awready = (wstate == W_IDLE);
  assign wready  = (wstate == W_DATA);

  // Per-beat decode of the current write address and protocol errors.
  always_comb begin
    w_hs       = (wstate == W_DATA) && wvalid;
    w_inr      = in_range(w_addr);
    w_idx      = word_idx(w_addr);
    w_final    = (w_cnt == w_len);
    w_beat_err = !w_inr || (wlast != w_final);
  end

  // Array update: only strobed lanes of in-range beats; the array has no reset.
  always_ff @(posedge clk) begin
    if (w_hs && w_inr) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[w_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Write FSM: latch AW, accept beats until counter==len, then hold B until bready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wstate <= W_IDLE;
      bvalid <= 1'b0;
      bid    <= 4'd0;
      bresp  <= OKAY;
      w_id   <= 4'd0;
      w_addr <= 32'd0;
      w_len  <= 8'd0;
      w_size <= 3'd0;
      w_mode <= M_INCR;
      w_err  <= 1'b0;
      w_cnt  <= 8'd0;
    end else begin
      case (wstate)
        W_IDLE: begin
          if (awvalid) begin
            w_id   <= awid;
            w_addr <= awaddr;
            w_len  <= awlen;
            w_size <= awsize;
            w_mode <= burst_mode(awburst, awlen);
            w_err  <= burst_err(awburst, awlen);
            w_cnt  <= 8'd0;
            wstate <= W_DATA;
          end
        end
        W_DATA: begin
          if (wvalid) begin
            if (w_final) begin
              bvalid <= 1'b1;
              bid    <= w_id;
              bresp  <= (w_err || w_beat_err) ? SLVERR : OKAY;
              wstate <= W_RESP;
            end else begin
              w_err  <= w_err || w_beat_err;
              w_cnt  <= w_cnt + 8'd1;
              w_addr <= next_addr(w_addr, w_size, w_len, w_mode);
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid <= 1'b0;
            wstate <= W_IDLE;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Bench for axi_sram_slave: directed scenarios followed by random bursts, all
// checked against a word-array reference model and burst-address arithmetic.
module tb_axi_sram_slave;

  localparam logic [31:0] BASE  = 32'h1c00_0000;
  localparam int          WORDS = 4096;
  localparam int          LAT   = 2;
  localparam int          GUARD = 64;

  logic        clk;
  logic        reset;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  axi_sram_slave #(.MEM_WORDS(WORDS), .BASE_ADDR(BASE), .READ_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard and reference model ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] model_mem [WORDS];
  bit          model_vld [WORDS];
  logic [31:0] exp_q[$];
  logic [1:0]  exp_resp_q[$];
  bit          exp_vld_q[$];
  logic [31:0] wd [256];
  logic [3:0]  ws [256];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit wrap_ok(input logic [7:0] len);
    return len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15;
  endfunction

  function automatic bit bad_burst(input logic [1:0] b, input logic [7:0] len);
    return b == 2'b11 || (b == 2'b10 && !wrap_ok(len));
  endfunction

  // Address of beat i, written directly from the burst definitions.
  function automatic logic [31:0] beat_addr(input logic [31:0] start, input logic [7:0] len,
                                            input logic [2:0] size, input logic [1:0] burst,
                                            input int i);
    int unsigned bytes, total, lower;
    bytes = 32'd1 << size;
    total = (int'(len) + 1) * bytes;
    if (burst == 2'b00) return start;
    if (burst == 2'b10 && wrap_ok(len)) begin
      lower = start - (start % total);
      return lower + (((start - lower) + i * bytes) % total);
    end
    return start + i * bytes;
  endfunction

  function automatic bit m_inr(input logic [31:0] a);
    return a >= BASE && a < BASE + 32'(4 * WORDS);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string p);
    chk({p, "_arready"}, {31'd0, arready}, 32'd1);
    chk({p, "_awready"}, {31'd0, awready}, 32'd1);
    chk({p, "_rvalid"},  {31'd0, rvalid},  32'd0);
    chk({p, "_wready"},  {31'd0, wready},  32'd0);
    chk({p, "_bvalid"},  {31'd0, bvalid},  32'd0);
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input int bad_wlast_beat, input int gap_max, input int bhold);
    int guard;
    bit exp_err;
    logic [31:0] a;
    logic [31:0] cap_bid, cap_bresp;
    exp_err = bad_burst(burst, len);
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    guard = 0;
    while (!awready && guard < GUARD) begin tick(); guard++; end
    tick();
    awvalid = 1'b0;
    chk("aw_timeout", {31'd0, guard >= GUARD}, 32'd0);
    for (int i = 0; i <= int'(len); i++) begin
      if (gap_max > 0) begin
        wvalid = 1'b0;
        repeat ($urandom_range(0, gap_max)) tick();
      end
      wdata  = wd[i];
      wstrb  = ws[i];
      wlast  = (i == int'(len)) ^ (i == bad_wlast_beat);
      wvalid = 1'b1;
      guard = 0;
      while (!wready && guard < GUARD) begin tick(); guard++; end
      if (guard >= GUARD) chk("w_timeout", {31'd0, wready}, 32'd1);
      tick();
      a = beat_addr(addr, len, size, burst, i);
      if (m_inr(a)) begin
        for (int b = 0; b < 4; b++)
          if (ws[i][b]) model_mem[word_of(a)][8*b +: 8] = wd[i][8*b +: 8];
        if (ws[i] == 4'hf) model_vld[word_of(a)] = 1'b1;
      end else begin
        exp_err = 1'b1;
      end
      if (wlast != (i == int'(len))) exp_err = 1'b1;
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    guard = 0;
    while (!bvalid && guard < GUARD) begin tick(); guard++; end
    chk("b_timeout", {31'd0, guard >= GUARD}, 32'd0);
    chk("bid", {28'd0, bid}, {28'd0, id});
    chk("bresp", {30'd0, bresp}, exp_err ? 32'd2 : 32'd0);
    cap_bid = {28'd0, bid}; cap_bresp = {30'd0, bresp};
    repeat (bhold) begin
      tick();
      chk("b_hold_valid", {31'd0, bvalid}, 32'd1);
      chk("b_hold_bid", {28'd0, bid}, cap_bid);
      chk("b_hold_bresp", {30'd0, bresp}, cap_bresp);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("b_done", {31'd0, bvalid}, 32'd0);
  endtask

  task automatic ar_issue(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    int guard;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    guard = 0;
    while (!arready && guard < GUARD) begin tick(); guard++; end
    tick();
    arvalid = 1'b0;
    chk("ar_timeout", {31'd0, guard >= GUARD}, 32'd0);
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst,
                         input int bp_beat, input int bp_cycles, input bit check_lat);
    int lat;
    logic [31:0] a, ed, cap_d;
    logic [1:0]  er;
    bit          ev, cap_l;
    for (int i = 0; i <= int'(len); i++) begin
      a = beat_addr(addr, len, size, burst, i);
      if (m_inr(a)) begin
        exp_q.push_back(model_mem[word_of(a)]);
        exp_resp_q.push_back(bad_burst(burst, len) ? 2'b10 : 2'b00);
        exp_vld_q.push_back(model_vld[word_of(a)]);
      end else begin
        exp_q.push_back(32'd0);
        exp_resp_q.push_back(2'b10);
        exp_vld_q.push_back(1'b1);
      end
    end
    rready = 1'b0;
    ar_issue(id, addr, len, size, burst);
    lat = 0;
    while (!rvalid && lat < GUARD) begin tick(); lat++; end
    if (check_lat) chk("r_latency", 32'(lat), 32'(LAT + 1));
    else           chk("r_timeout", {31'd0, lat >= GUARD}, 32'd0);
    for (int i = 0; i <= int'(len); i++) begin
      ed = exp_q.pop_front();
      er = exp_resp_q.pop_front();
      ev = exp_vld_q.pop_front();
      chk("rvalid_beat", {31'd0, rvalid}, 32'd1);
      if (i == bp_beat) begin
        cap_d = rdata; cap_l = rlast;
        repeat (bp_cycles) begin
          tick();
          chk("bp_rvalid", {31'd0, rvalid}, 32'd1);
          chk("bp_rdata", rdata, cap_d);
          chk("bp_rlast", {31'd0, rlast}, {31'd0, cap_l});
        end
      end
      if (ev) chk("rdata", rdata, ed);
      chk("rresp", {30'd0, rresp}, {30'd0, er});
      chk("rlast", {31'd0, rlast}, {31'd0, i == int'(len)});
      chk("rid", {28'd0, rid}, {28'd0, id});
      rready = 1'b1;
      tick();
      rready = 1'b0;
    end
    chk("r_done", {31'd0, rvalid}, 32'd0);
    chk("r_arready", {31'd0, arready}, 32'd1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] a;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          wsel;
    reset = 1'b1;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; rready = 1'b0; bready = 1'b0;
    for (int i = 0; i < WORDS; i++) model_vld[i] = 1'b0;
    repeat (3) tick();

    // Reset values, during and after reset.
    check_idle("rst");
    chk("rst_rlast", {31'd0, rlast}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_rid", {28'd0, rid}, 32'd0);
    chk("rst_rresp", {30'd0, rresp}, 32'd0);
    chk("rst_bid", {28'd0, bid}, 32'd0);
    chk("rst_bresp", {30'd0, bresp}, 32'd0);
    reset = 1'b0;
    tick();
    check_idle("post_rst");

    // Preload the random window (words 0..63) and the top of the array.
    for (int blk = 0; blk < 4; blk++) begin
      for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'hf; end
      do_write(4'(blk), BASE + 32'(blk * 64), 8'd15, 3'd2, 2'b01, -1, 0, 0);
    end
    for (int i = 0; i < 8; i++) begin wd[i] = $urandom; ws[i] = 4'hf; end
    do_write(4'd5, BASE + 32'(4 * (WORDS - 8)), 8'd7, 3'd2, 2'b01, -1, 0, 0);

    // Single-word write then read, with first-beat latency.
    wd[0] = 32'hdeadbeef; ws[0] = 4'hf;
    do_write(4'd1, 32'h1c00_0010, 8'd0, 3'd2, 2'b01, -1, 0, 1);
    do_read(4'd0, 32'h1c00_0010, 8'd0, 3'd2, 2'b01, -1, 0, 1'b1);

    // WRAP refill starting mid-line.
    for (int i = 0; i < 4; i++) begin wd[i] = 32'ha0 + 32'(i); ws[i] = 4'hf; end
    do_write(4'd2, 32'h1c00_0020, 8'd3, 3'd2, 2'b01, -1, 0, 0);
    do_read(4'd3, 32'h1c00_0028, 8'd3, 3'd2, 2'b10, -1, 0, 1'b1);

    // INCR write with a partial strobe over 0xffffffff, then backpressured read.
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hffff_ffff; ws[i] = 4'hf; end
    do_write(4'd4, 32'h1c00_0100, 8'd3, 3'd2, 2'b01, -1, 0, 0);
    for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hf; end
    ws[1] = 4'b0011;
    do_write(4'd6, 32'h1c00_0100, 8'd3, 3'd2, 2'b01, -1, 1, 0);
    do_read(4'd7, 32'h1c00_0100, 8'd3, 3'd2, 2'b01, -1, 0, 1'b0);
    do_read(4'd8, 32'h1c00_0100, 8'd3, 3'd2, 2'b01, 1, 3, 1'b0);

    // Out-of-range read and write, array unchanged, early wlast.
    do_read(4'd9, 32'h1c00_4000, 8'd3, 3'd2, 2'b01, -1, 0, 1'b0);
    wd[0] = 32'h1234_5678; ws[0] = 4'hf;
    do_write(4'd10, 32'h1c00_4000, 8'd0, 3'd2, 2'b01, -1, 0, 0);
    do_read(4'd11, BASE, 8'd3, 3'd2, 2'b01, -1, 0, 1'b0);
    wd[0] = 32'h5555_0000; wd[1] = 32'h5555_0001; ws[0] = 4'hf; ws[1] = 4'hf;
    do_write(4'd12, 32'h1c00_0040, 8'd1, 3'd2, 2'b01, 0, 0, 0);

    // Mid-burst reset on both channels.
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hc0 + 32'(i); ws[i] = 4'hf; end
    do_write(4'd13, 32'h1c00_0200, 8'd3, 3'd2, 2'b01, -1, 0, 0);
    awid = 4'd14; awaddr = 32'h1c00_0200; awlen = 8'd3; awsize = 3'd2; awburst = 2'b01;
    awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wdata = 32'h11 * 32'(i + 1); wstrb = 4'hf; wlast = 1'b0; wvalid = 1'b1;
      chk("mr_wready", {31'd0, wready}, 32'd1);
      tick();
      model_mem[word_of(32'h1c00_0200) + i] = 32'h11 * 32'(i + 1);
    end
    wvalid = 1'b0;
    ar_issue(4'd15, 32'h1c00_0200, 8'd3, 3'd2, 2'b01);
    repeat (LAT + 1) tick();
    for (int i = 0; i < 2; i++) begin
      chk("mr_rdata", rdata, model_mem[word_of(32'h1c00_0200) + i]);
      rready = 1'b1;
      tick();
      rready = 1'b0;
    end
    chk("mr_rvalid_b2", {31'd0, rvalid}, 32'd1);
    wdata = 32'h33; wvalid = 1'b1;
    reset = 1'b1;
    #1;
    check_idle("mr_in_rst");
    tick();
    tick();
    check_idle("mr_held_rst");
    reset = 1'b0;
    wvalid = 1'b0;
    repeat (4) tick();
    check_idle("mr_after");
    do_read(4'd1, 32'h1c00_0200, 8'd3, 3'd2, 2'b01, -1, 0, 1'b1);

    // Random bursts over the preloaded regions, occasionally crossing the top.
    for (int t = 0; t < 40; t++) begin
      burst = 2'($urandom_range(0, 3));
      len   = (burst == 2'b10 && $urandom_range(0, 1) == 1) ? 8'((2 << $urandom_range(0, 3)) - 1)
                                                             : 8'($urandom_range(0, 15));
      size  = 3'($urandom_range(0, 2));
      if ($urandom_range(0, 4) == 0) wsel = WORDS - 8 + int'($urandom_range(0, 7));
      else                           wsel = int'($urandom_range(0, 47));
      a = BASE + 32'(wsel * 4);
      if (size == 3'd0) a = a + 32'($urandom_range(0, 3));
      if (size == 3'd1) a = a + 32'(2 * $urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i <= int'(len); i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
        do_write(4'($urandom), a, len, size, burst,
                 ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 15)) : -1,
                 1, int'($urandom_range(0, 2)));
      end else begin
        do_read(4'($urandom), a, len, size, burst, int'($urandom_range(0, 15)),
                int'($urandom_range(0, 2)), 1'b1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
